decode_queue: RTL and testbench

- Multi-wide, buffered decode stage between fetch and rename/dispatch.
- Accepts fetch packets of up to FETCH_W 32-bit instruction words and stores them in a circular queue of DEPTH entries.
- Presents up to DEC_W decoded C::si_t per cycle, in program order. Each lane is decoded combinationally by the existing single-instruction decoder.
- Adds what single-instruction decode lacks: buffering, a valid/ready handshake, multi-lane issue, flush, and an illegal-instruction halt.

---
 rtl/C.sv | 61 ++++++
 rtl/decode_queue.sv | 109 ++++++++++
 tb/tb_decode_queue.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/C.sv
// Core-wide constants, the decoded-instruction record and the single-instruction
// RV32I decoder used by the decode stage.
package C;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     word;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
    } si_t;

    // Any opcode outside the RV32I base set decodes with valid=0.
    function automatic si_t decode(input logic [XLEN-1:0] pc, input logic [31:0] word);
        si_t si;
        si        = '0;
        si.pc     = pc;
        si.word   = word;
        si.opcode = word[6:0];
        si.rd     = word[11:7];
        si.funct3 = word[14:12];
        si.rs1    = word[19:15];
        si.rs2    = word[24:20];
        case (word[6:0])
            7'b0110111, 7'b0010111: begin
                si.valid = 1'b1;
                si.imm   = {word[31:12], 12'b0};
            end
            7'b1101111: begin
                si.valid = 1'b1;
                si.imm   = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                si.valid = 1'b1;
                si.imm   = {{20{word[31]}}, word[31:20]};
            end
            7'b0100011: begin
                si.valid = 1'b1;
                si.imm   = {{20{word[31]}}, word[31:25], word[11:7]};
            end
            7'b1100011: begin
                si.valid = 1'b1;
                si.imm   = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
            end
            7'b0110011, 7'b0001111, 7'b1110011: begin
                si.valid = 1'b1;
            end
            default: begin
                si.valid = 1'b0;
            end
        endcase
        return si;
    endfunction

endpackage

// File: rtl/decode_queue.sv
// Buffered multi-wide decode stage: a circular queue of fetched {pc, word} entries
// feeding up to DEC_W decoded lanes per cycle, halting after an illegal instruction issues.
module decode_queue #(
    parameter int FETCH_W = 2,
    parameter int DEC_W   = 2,
    parameter int DEPTH   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [C::XLEN-1:0]         fetch_pc_i,
    input  logic [32*FETCH_W-1:0]      fetch_data_i,
    input  logic [FETCH_W-1:0]         fetch_mask_i,
    output logic [DEC_W-1:0]           dec_valid_o,
    output C::si_t [DEC_W-1:0]         dec_si_o,
    input  logic                       dec_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam int XW = C::XLEN;

    typedef enum logic {RUN, HALT} state_t;

    state_t          state;
    logic [XW-1:0]   pc_mem   [DEPTH];
    logic [31:0]     word_mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   enq_n;
    logic [CW-1:0]   deq_n;
    logic            enq_fire;
    logic            illegal_deq;
    logic            lane_stop;

    // Ready uses the pre-dequeue count so it never depends on dec_ready_i.
    assign fetch_ready_o = (state == RUN) && !flush_i && (count <= CW'(DEPTH - FETCH_W));
    assign enq_fire      = fetch_valid_i && fetch_ready_o;
    assign count_o       = count;

    // Lanes stay contiguous and stop just after the first illegal decode, which is
    // itself presented so the backend can trap on it.
    always_comb begin
        dec_valid_o = '0;
        dec_si_o    = '0;
        deq_n       = '0;
        enq_n       = '0;
        illegal_deq = 1'b0;
        lane_stop   = (state != RUN) || flush_i;
        for (int i = 0; i < DEC_W; i++) begin
            if (CW'(i) < count) begin
                dec_si_o[i] = C::decode(pc_mem[head + PW'(i)], word_mem[head + PW'(i)]);
            end
            if (!lane_stop && (CW'(i) < count)) begin
                dec_valid_o[i] = 1'b1;
                if (!dec_si_o[i].valid) begin
                    lane_stop = 1'b1;
                end
            end else begin
                lane_stop = 1'b1;
            end
        end
        for (int i = 0; i < DEC_W; i++) begin
            if (dec_ready_i && dec_valid_o[i]) begin
                deq_n = deq_n + CW'(1);
                if (!dec_si_o[i].valid) begin
                    illegal_deq = 1'b1;
                end
            end
        end
        for (int k = 0; k < FETCH_W; k++) begin
            if (enq_fire && fetch_mask_i[k]) begin
                enq_n = enq_n + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (fetch_mask_i[k]) begin
                    pc_mem[tail + PW'(k)]   <= fetch_pc_i + XW'(4 * k);
                    word_mem[tail + PW'(k)] <= fetch_data_i[32*k +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state <= RUN;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + enq_n[PW-1:0];
            head  <= head + deq_n[PW-1:0];
            count <= count + enq_n - deq_n;
            if (illegal_deq) begin
                state <= HALT;
            end
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue with FETCH_W=2, DEC_W=2, DEPTH=8.
module tb_decode_queue;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] ILL  = 32'h00000000;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic            fetch_valid_i = 1'b0;
    logic            fetch_ready_o;
    logic [31:0]     fetch_pc_i = '0;
    logic [63:0]     fetch_data_i = '0;
    logic [1:0]      fetch_mask_i = '0;
    logic [1:0]      dec_valid_o;
    C::si_t [1:0]    dec_si_o;
    logic            dec_ready_i = 1'b0;
    logic [3:0]      count_o;

    int checks = 0;
    int errors = 0;

    decode_queue #(.FETCH_W(2), .DEC_W(2), .DEPTH(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_data_i  (fetch_data_i),
        .fetch_mask_i  (fetch_mask_i),
        .dec_valid_o   (dec_valid_o),
        .dec_si_o      (dec_si_o),
        .dec_ready_i   (dec_ready_i),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] addi(input logic [11:0] imm);
        return {imm, 5'd0, 3'd0, 5'd1, 7'b0010011};
    endfunction

    function automatic logic mask_contig(input logic [1:0] m);
        logic [2:0] e;
        e = {1'b0, m};
        return (e & (e + 3'd1)) == 3'd0;
    endfunction

    // A gapped fetch mask is a protocol violation on the fetch side.
    always @(negedge clk_i) begin
        if (!rst_i && fetch_valid_i && fetch_ready_o) begin
            assert (mask_contig(fetch_mask_i)) else begin
                errors++;
                $error("[TB] FAIL mask_contig: observed=%b required=contiguous", fetch_mask_i);
            end
        end
    end

    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [63:0] data,
                                 input logic [1:0] mask, input logic ready, input logic flush);
        fetch_valid_i = valid;
        fetch_pc_i    = pc;
        fetch_data_i  = data;
        fetch_mask_i  = mask;
        dec_ready_i   = ready;
        flush_i       = flush;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        $display("[TB] starting decode_queue bench");
        idle();
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        checkOutput("rst_count", count_o, 0);
        checkOutput("rst_valid", dec_valid_o, 0);
        checkOutput("rst_ready", fetch_ready_o, 1);
        checkOutput("rst_si_xfree", {63'd0, $isunknown(dec_si_o)}, 0);

        // Single packet
        applyStimulus(1'b1, 32'h1000, {ADD, ADDI}, 2'b11, 1'b0, 1'b0);
        checkOutput("p1_ready", fetch_ready_o, 1);
        checkOutput("p1_no_bypass", dec_valid_o, 0);
        tick();
        idle();
        checkOutput("p1_valid", dec_valid_o, 2'b11);
        checkOutput("p1_l0_word", dec_si_o[0].word, ADDI);
        checkOutput("p1_l1_pc", dec_si_o[1].pc, 32'h1004);
        checkOutput("p1_l1_word", dec_si_o[1].word, ADD);
        checkOutput("p1_count", count_o, 2);
        applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("p1_drained", count_o, 0);
        checkOutput("p1_drained_valid", dec_valid_o, 0);

        // Partial mask
        applyStimulus(1'b1, 32'h2000, {NOP, ADDI}, 2'b01, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("pm_count", count_o, 1);
        checkOutput("pm_valid", dec_valid_o, 2'b01);
        applyStimulus(1'b1, 32'h2100, {ADDI, ADD}, 2'b11, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("pm_count2", count_o, 3);
        checkOutput("pm_l0_pc", dec_si_o[0].pc, 32'h2000);
        checkOutput("pm_l1_pc", dec_si_o[1].pc, 32'h2100);
        checkOutput("pm_l1_word", dec_si_o[1].word, ADD);
        applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0);
        tick();
        checkOutput("pm_count_after1", count_o, 1);
        tick();
        idle();
        checkOutput("pm_drained", count_o, 0);

        // Fill to full
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1'b1, 32'h3000 + 32'(8 * p), {addi(12'(2 * p + 1)), addi(12'(2 * p))},
                          2'b11, 1'b0, 1'b0);
            tick();
        end
        idle();
        checkOutput("full_count", count_o, 8);
        checkOutput("full_ready", fetch_ready_o, 0);
        checkOutput("full_l0_pc", dec_si_o[0].pc, 32'h3000);
        checkOutput("full_l1_word", dec_si_o[1].word, addi(12'd1));
        applyStimulus(1'b1, 32'h9000, {NOP, NOP}, 2'b11, 1'b1, 1'b0);
        checkOutput("full_deq_ready", fetch_ready_o, 0);
        tick();
        idle();
        checkOutput("after_deq_count", count_o, 6);
        checkOutput("after_deq_ready", fetch_ready_o, 1);
        checkOutput("after_deq_l0_pc", dec_si_o[0].pc, 32'h3008);

        // Simultaneous enqueue and dequeue at count 6
        applyStimulus(1'b1, 32'h3020, {addi(12'd9), addi(12'd8)}, 2'b11, 1'b1, 1'b0);
        checkOutput("sim_valid", dec_valid_o, 2'b11);
        tick();
        idle();
        checkOutput("sim_count", count_o, 6);
        checkOutput("sim_l0_pc", dec_si_o[0].pc, 32'h3010);

        // Flush wins over a presented fetch
        applyStimulus(1'b1, 32'h9100, {NOP, NOP}, 2'b11, 1'b0, 1'b1);
        checkOutput("fl_ready", fetch_ready_o, 0);
        checkOutput("fl_valid", dec_valid_o, 0);
        tick();
        idle();
        checkOutput("fl_count", count_o, 0);
        checkOutput("fl_ready_after", fetch_ready_o, 1);
        checkOutput("fl_valid_after", dec_valid_o, 0);

        // Streaming across pointer wrap
        for (int p = 0; p < 20; p++) begin
            applyStimulus(1'b1, 32'h4000 + 32'(8 * p), {addi(12'(2 * p + 1)), addi(12'(2 * p))},
                          2'b11, 1'b1, 1'b0);
            if (p == 0) begin
                checkOutput("st_first_valid", dec_valid_o, 0);
            end else begin
                checkOutput("st_valid", dec_valid_o, 2'b11);
                checkOutput("st_l0_pc", dec_si_o[0].pc, 32'h4000 + 32'(8 * (p - 1)));
                checkOutput("st_l1_word", dec_si_o[1].word, addi(12'(2 * p - 1)));
                checkOutput("st_count", count_o, 2);
            end
            tick();
        end
        applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0);
        checkOutput("st_last_pc", dec_si_o[0].pc, 32'h4098);
        checkOutput("st_last_word", dec_si_o[1].word, addi(12'd39));
        tick();
        idle();
        checkOutput("st_drained", count_o, 0);

        // Illegal instruction mid-packet
        applyStimulus(1'b1, 32'h5000, {ILL, ADDI}, 2'b11, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h5008, {NOP, ADD}, 2'b01, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("ill_count", count_o, 3);
        checkOutput("ill_valid", dec_valid_o, 2'b11);
        checkOutput("ill_l0_legal", dec_si_o[0].valid, 1);
        checkOutput("ill_l1_legal", dec_si_o[1].valid, 0);
        checkOutput("ill_l1_pc", dec_si_o[1].pc, 32'h5004);
        applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("halt_valid", dec_valid_o, 0);
        checkOutput("halt_ready", fetch_ready_o, 0);
        checkOutput("halt_count", count_o, 1);
        applyStimulus(1'b1, 32'h9200, {NOP, NOP}, 2'b11, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("halt_hold_count", count_o, 1);
        checkOutput("halt_hold_valid", dec_valid_o, 0);
        applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("unhalt_count", count_o, 0);
        checkOutput("unhalt_ready", fetch_ready_o, 1);

        // New fetch after flush, then reset while halted with 5 entries
        applyStimulus(1'b1, 32'h6000, {ILL, ADDI}, 2'b11, 1'b0, 1'b0);
        checkOutput("refetch_ready", fetch_ready_o, 1);
        tick();
        for (int p = 1; p < 4; p++) begin
            applyStimulus(1'b1, 32'h6000 + 32'(8 * p), {ADDI, ADDI}, (p == 3) ? 2'b01 : 2'b11,
                          1'b0, 1'b0);
            tick();
        end
        idle();
        checkOutput("rh_count7", count_o, 7);
        checkOutput("rh_valid", dec_valid_o, 2'b11);
        applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("rh_count5", count_o, 5);
        checkOutput("rh_halt_valid", dec_valid_o, 0);
        checkOutput("rh_halt_ready", fetch_ready_o, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        checkOutput("rh_rst_count", count_o, 0);
        checkOutput("rh_rst_ready", fetch_ready_o, 1);
        checkOutput("rh_rst_valid", dec_valid_o, 0);

        // Illegal instruction in lane 0 masks lane 1
        applyStimulus(1'b1, 32'h8000, {ADDI, ILL}, 2'b11, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("l0ill_valid", dec_valid_o, 2'b01);
        checkOutput("l0ill_legal", dec_si_o[0].valid, 0);
        checkOutput("l0ill_count", count_o, 2);
        applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("l0ill_halt_count", count_o, 1);
        checkOutput("l0ill_halt_valid", dec_valid_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
